// File: rtl/servo_pwm_bank_if.sv
// Bus bundle for servo_pwm_bank: run request, duty write port and pulse/status outputs.
interface servo_pwm_bank_if #(
    parameter int unsigned NCH  = 5,
    parameter int unsigned DBIT = 20
);
    logic                en;
    logic [NCH*DBIT-1:0] duty_in;
    logic [NCH-1:0]      duty_wr;
    logic [NCH-1:0]      pwm_out;
    logic                frame_start;
    logic                busy;

    modport master (
        output en, duty_in, duty_wr,
        input  pwm_out, frame_start, busy
    );

    modport slave (
        input  en, duty_in, duty_wr,
        output pwm_out, frame_start, busy
    );
endinterface

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM: one shared frame counter, per-channel shadow/active duty.
// Optional feature macro SLEW_LIMIT_EN limits per-frame duty change to SLEW_STEP.
module servo_pwm_bank #(
    parameter int unsigned NCH       = 5,
    parameter int unsigned PERIOD    = 1000000,
    parameter int unsigned PBIT      = 20,
    parameter int unsigned DBIT      = 20,
    parameter int unsigned DMIN      = 50000,
    parameter int unsigned DMAX      = 100000,
    parameter int unsigned SLEW_STEP = 1000
) (
    input logic              clk,
    input logic              reset,
    servo_pwm_bank_if.slave  bus
);

    localparam int unsigned     CW      = (PBIT > DBIT) ? PBIT : DBIT;
    localparam logic [PBIT-1:0] LastCnt = PBIT'(PERIOD - 1);
    localparam logic [DBIT-1:0] DMinW   = DBIT'(DMIN);
    localparam logic [DBIT-1:0] DMaxW   = DBIT'(DMAX);
    localparam logic [DBIT-1:0] Neutral = DBIT'((DMIN + DMAX) / 2);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [PBIT-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]  pwm_q, pwm_d;
    logic            fs_q, fs_d;
    logic            busy_q, busy_d;
    logic [DBIT-1:0] shadow_q [NCH];
    logic [DBIT-1:0] shadow_d [NCH];
    logic [DBIT-1:0] act_q    [NCH];
    logic [DBIT-1:0] act_d    [NCH];
    logic            load;

    function automatic logic [DBIT-1:0] clamp_duty(logic [DBIT-1:0] x);
        if (x < DMinW) return DMinW;
        if (x > DMaxW) return DMaxW;
        return x;
    endfunction

`ifdef SLEW_LIMIT_EN
    localparam logic [DBIT-1:0] Step = DBIT'(SLEW_STEP);

    function automatic logic [DBIT-1:0] slew_toward(logic [DBIT-1:0] tgt, logic [DBIT-1:0] cur);
        if (tgt > cur) return (tgt - cur <= Step) ? tgt : cur + Step;
        return (cur - tgt <= Step) ? tgt : cur - Step;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        fs_d    = 1'b0;
        pwm_d   = '0;
        act_d   = act_q;
        for (int i = 0; i < NCH; i++) begin
            shadow_d[i] = bus.duty_wr[i] ? clamp_duty(bus.duty_in[i*DBIT +: DBIT]) : shadow_q[i];
        end

        unique case (state_q)
            StIdle: begin
                if (bus.en) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            StRun: begin
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    if (bus.en) load = 1'b1;
                    else        state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Frame-start load sees the pre-write shadow; a same-cycle write waits a frame.
        if (load) begin
            fs_d = 1'b1;
            for (int i = 0; i < NCH; i++) begin
`ifdef SLEW_LIMIT_EN
                act_d[i] = slew_toward(shadow_q[i], act_q[i]);
`else
                act_d[i] = shadow_q[i];
`endif
            end
        end

        busy_d = (state_d == StRun);
        if (state_d == StRun) begin
            for (int i = 0; i < NCH; i++) begin
                pwm_d[i] = CW'(cnt_d) < CW'(act_d[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pwm_q   <= '0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= Neutral;
                act_q[i]    <= Neutral;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pwm_q    <= pwm_d;
            fs_q     <= fs_d;
            busy_q   <= busy_d;
            shadow_q <= shadow_d;
            act_q    <= act_d;
        end
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.frame_start = fs_q;
    assign bus.busy        = busy_q;

`ifndef SYNTHESIS
    // Slew step must also fit the duty width since it is added to act_duty.
    localparam bit ParamsOk = (DMIN <= DMAX) && (DMAX < PERIOD) &&
                              (64'(PERIOD) <= (64'(1) << PBIT) - 64'(1)) &&
                              (64'(DMAX) < (64'(1) << DBIT)) &&
                              (64'(SLEW_STEP) < (64'(1) << DBIT));
    assert property (@(posedge clk) ParamsOk);
`endif

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Randomised and directed bench for servo_pwm_bank against a frame-level reference model.
module tb_servo_pwm_bank;

    localparam int NCH    = 3;
    localparam int PERIOD = 200;
    localparam int DBIT   = 8;
    localparam int DMIN   = 20;
    localparam int DMAX   = 40;
    localparam int STEP   = 4;

    logic clk = 1'b0;
    logic reset;

    servo_pwm_bank_if #(.NCH(NCH), .DBIT(DBIT)) bus ();

    servo_pwm_bank #(
        .NCH       (NCH),
        .PERIOD    (PERIOD),
        .PBIT      (8),
        .DBIT      (DBIT),
        .DMIN      (DMIN),
        .DMAX      (DMAX),
        .SLEW_STEP (STEP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame position, requested and active widths per channel.
    bit m_run;
    bit m_fs;
    int m_pos;
    int m_shadow [NCH];
    int m_act    [NCH];
    bit exp_pwm  [NCH];
    int width    [NCH];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int x);
        return (x < DMIN) ? DMIN : ((x > DMAX) ? DMAX : x);
    endfunction

    function automatic int next_width(input int tgt, input int cur);
`ifdef SLEW_LIMIT_EN
        int diff = tgt - cur;
        if (diff > STEP)  return cur + STEP;
        if (diff < -STEP) return cur - STEP;
        return tgt;
`else
        return tgt;
`endif
    endfunction

    task automatic model_reset();
        m_run = 0;
        m_fs  = 0;
        m_pos = 0;
        for (int i = 0; i < NCH; i++) begin
            m_shadow[i] = (DMIN + DMAX) / 2;
            m_act[i]    = (DMIN + DMAX) / 2;
            exp_pwm[i]  = 0;
        end
    endtask

    task automatic model_step(input bit e, input logic [NCH-1:0] wr, input logic [NCH*DBIT-1:0] din);
        bit load = 0;
        if (!m_run) begin
            if (e) begin
                m_run = 1;
                m_pos = 0;
                load  = 1;
            end
        end else if (m_pos == PERIOD - 1) begin
            m_pos = 0;
            if (e) load = 1;
            else   m_run = 0;
        end else begin
            m_pos++;
        end
        m_fs = load;
        if (load) for (int i = 0; i < NCH; i++) m_act[i] = next_width(m_shadow[i], m_act[i]);
        for (int i = 0; i < NCH; i++) begin
            if (wr[i]) m_shadow[i] = clamp(int'(din[i*DBIT +: DBIT]));
            exp_pwm[i] = m_run && (m_pos < m_act[i]);
        end
    endtask

    task automatic tick();
        bit                  e   = bus.en;
        logic [NCH-1:0]      wr  = bus.duty_wr;
        logic [NCH*DBIT-1:0] din = bus.duty_in;
        @(posedge clk);
        model_step(e, wr, din);
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("pwm_ch%0d", i), int'(bus.pwm_out[i]), int'(exp_pwm[i]));
            width[i] += int'(bus.pwm_out[i]);
        end
        check("frame_start", int'(bus.frame_start), int'(m_fs));
        check("busy", int'(bus.busy), int'(m_run));
    endtask

    task automatic advance_to(input int target);
        int n = 0;
        while (!(m_run && m_pos == target)) begin
            tick();
            n++;
            if (n > 3 * PERIOD) begin
                check("advance_timeout", n, 0);
                break;
            end
        end
    endtask

    // Runs one full frame whose first edge is the frame-start load; optional write at cycle wr_at.
    task automatic run_frame(input int e0, input int e1, input int e2, input int wr_at,
                             input logic [NCH-1:0] mask, input int v0, input int v1, input int v2);
        for (int i = 0; i < NCH; i++) width[i] = 0;
        for (int k = 0; k < PERIOD; k++) begin
            if (k == wr_at) begin
                bus.duty_wr = mask;
                bus.duty_in = {8'(v2), 8'(v1), 8'(v0)};
            end
            tick();
            bus.duty_wr = '0;
            if (k == 0) check("frame_start_at0", int'(bus.frame_start), 1);
        end
        check("width_ch0", width[0], e0);
        check("width_ch1", width[1], e1);
        check("width_ch2", width[2], e2);
    endtask

    initial begin
        reset       = 1'b1;
        bus.en      = 1'b0;
        bus.duty_wr = '0;
        bus.duty_in = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_pwm", int'(bus.pwm_out), 0);
        check("reset_fs", int'(bus.frame_start), 0);
        check("reset_busy", int'(bus.busy), 0);
        reset = 1'b0;
        repeat (3) tick();

        bus.en = 1'b1;
`ifdef SLEW_LIMIT_EN
        run_frame(30, 30, 30, 100, 3'b001, 40, 0, 0);
        run_frame(34, 30, 30, -1, 3'b000, 0, 0, 0);
        run_frame(38, 30, 30, -1, 3'b000, 0, 0, 0);
        run_frame(40, 30, 30, -1, 3'b000, 0, 0, 0);
`else
        run_frame(30, 30, 30, -1, 3'b000, 0, 0, 0);
        run_frame(30, 30, 30, 100, 3'b011, 5, 90, 0);
        run_frame(20, 40, 30, 100, 3'b001, 35, 0, 0);
        run_frame(35, 40, 30, 0, 3'b010, 0, 25, 0);
        run_frame(35, 25, 30, -1, 3'b000, 0, 0, 0);
`endif

        // Dropping en mid-frame completes the frame, then idles.
        advance_to(50);
        bus.en = 1'b0;
        advance_to(PERIOD - 1);
        check("busy_last_cycle", int'(bus.busy), 1);
        tick();
        check("busy_after_drop", int'(bus.busy), 0);
        check("pwm_after_drop", int'(bus.pwm_out), 0);
        repeat (5) tick();
        check("pwm_idle", int'(bus.pwm_out), 0);
        bus.en = 1'b1;
        tick();
        check("fs_rearm", int'(bus.frame_start), 1);
        check("busy_rearm", int'(bus.busy), 1);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                bus.duty_wr = 3'($urandom);
                bus.duty_in = 24'($urandom);
            end
            if ($urandom_range(0, 299) == 0) bus.en = ~bus.en;
            tick();
            bus.duty_wr = '0;
        end

        // Asynchronous reset mid-frame.
        bus.en = 1'b1;
        advance_to(10);
        #2 reset = 1'b1;
        #1 check("pwm_async_reset", int'(bus.pwm_out), 0);
        model_reset();
        @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_fs", int'(bus.frame_start), 0);
        bus.en = 1'b0;
        reset  = 1'b0;
        repeat (5) tick();
        check("pwm_after_release", int'(bus.pwm_out), 0);
        bus.en = 1'b1;
        run_frame(30, 30, 30, -1, 3'b000, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/servo_pwm_bank.md
SERVO_PWM_BANK -- requirements
Module: servo_pwm_bank

Interface
REQ-001 The block SHALL have parameter NCH, default 5, giving the number of independent servo channels.
REQ-002 The block SHALL have parameter PERIOD, default 1000000, giving the frame length in clk cycles (50 Hz at 50 MHz).
REQ-003 The block SHALL have parameter PBIT, default 20, giving the frame-counter width.
REQ-004 The block SHALL have parameter DBIT, default 20, giving the per-channel duty width.
REQ-005 The block SHALL have parameter DMIN, default 50000, giving the minimum pulse width in cycles (1 ms).
REQ-006 The block SHALL have parameter DMAX, default 100000, giving the maximum pulse width in cycles (2 ms).
REQ-007 The block SHALL have parameter SLEW_STEP, default 1000, giving the maximum per-frame duty change in cycles; it is used only under SLEW_LIMIT_EN.
REQ-008 clk  input  1  system clock; all state is rising-edge.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 en  input  1  run request; level-sensitive.
REQ-011 duty_in  input  NCH*DBIT  packed duty requests; channel i occupies bits [i*DBIT +: DBIT].
REQ-012 duty_wr  input  NCH  per-channel write strobe for duty_in.
REQ-013 pwm_out  output  NCH  registered servo pulse outputs.
REQ-014 frame_start  output  1  registered one-cycle pulse on the first cycle of each frame.
REQ-015 busy  output  1  registered; high while in state RUN.

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE (counter held at 0, pwm_out all 0) and RUN.
REQ-017 In IDLE, en=1 SHALL cause a transition to RUN; the next cycle is frame cycle 0, with frame_start=1.
REQ-018 In RUN, the shared counter SHALL increment from 0 to PERIOD-1, then wrap to 0 if en=1, or return to IDLE if en=0.
- Consequence: deasserting en mid-frame always completes the current frame.
REQ-019 pwm_out[i] SHALL be 1 exactly on frame cycles where counter < act_duty[i], giving act_duty[i] high cycles per frame starting at frame cycle 0.
REQ-020 duty_wr[i]=1 SHALL write the clamped duty_in slice i into shadow[i] on that clock edge.
- Clamp rule: min(max(x, DMIN), DMAX), applied as an unsigned DBIT-bit comparison.
REQ-021 act_duty[i] SHALL be loaded from shadow[i] only at frame start (IDLE->RUN transition or wrap); mid-frame writes SHALL NOT alter the running frame.
REQ-022 A write in the same cycle as a frame-start load SHALL land in shadow and take effect at the following frame; the load uses the pre-write shadow value.
REQ-023 Simultaneous writes to several channels SHALL all be accepted in the same cycle; channels SHALL be fully independent.
REQ-024 Repeated writes within one frame SHALL keep only the last value (no queueing).
REQ-025 Parameter legality SHALL be DMIN <= DMAX < PERIOD <= 2^PBIT-1 and DMAX < 2^DBIT; legality is checked by a simulation-only assertion.

Reset
REQ-026 On reset: state SHALL be IDLE, counter 0, pwm_out 0, frame_start 0, busy 0, and all shadow and act_duty SHALL be (DMIN+DMAX)/2 (75000 = neutral).
REQ-027 Reset asserted mid-frame SHALL drive pwm_out low immediately (asynchronously); after release, no output SHALL pulse until en is sampled high.

Configuration
REQ-028 With SLEW_LIMIT_EN defined, act_duty[i] SHALL be loaded at each frame start as shadow[i] if |shadow[i]-act_duty[i]| <= SLEW_STEP, else as act_duty[i] +/- SLEW_STEP toward shadow[i].
REQ-029 Without SLEW_LIMIT_EN, act_duty[i] SHALL be loaded directly from shadow[i], SLEW_STEP SHALL be ignored, and no slew logic SHALL be synthesised.

Verification
REQ-030 Bench parameters: PERIOD=200, DMIN=20, DMAX=40, NCH=3. Scenario: reset, en=1 -> frame_start every 200 cycles, each channel high 30 cycles per frame.
REQ-031 Scenario: write duty 5 to ch0 and 90 to ch1 -> next frame shows ch0 high 20 cycles, ch1 high 40 cycles, ch2 unchanged at 30.
REQ-032 Scenario: write 35 to ch0 at frame cycle 100 -> current frame keeps the old width; the next frame is 35; a write on the frame-start load cycle appears one frame later.
REQ-033 Scenario: drop en at frame cycle 50 -> the frame runs to cycle 199, then busy=0 and pwm_out=0; re-raising en gives frame_start on the following cycle.
REQ-034 Scenario: assert reset at frame cycle 10 -> pwm_out=0 in the same cycle, all widths return to 30.
REQ-035 Scenario (SLEW_LIMIT_EN, SLEW_STEP=4): write 40 from 30 -> successive frames give 34, 38, 40.
